// File: rtl/wb_arb2_led.sv
// wb_arb2_led: two-master round-robin Wishbone pipelined arbiter with outstanding tracking and ack timeout
module wb_arb2_led #(
  parameter int AW = 1,
  parameter int DW = 32,
  parameter int TIMEOUT = 64
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  input  logic          m0_we_i,
  input  logic [AW-1:0] m0_adr_i,
  input  logic [DW-1:0] m0_dat_i,
  output logic          m0_stall_o,
  output logic          m0_ack_o,
  output logic          m0_err_o,
  output logic [DW-1:0] m0_dat_o,
  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  input  logic          m1_we_i,
  input  logic [AW-1:0] m1_adr_i,
  input  logic [DW-1:0] m1_dat_i,
  output logic          m1_stall_o,
  output logic          m1_ack_o,
  output logic          m1_err_o,
  output logic [DW-1:0] m1_dat_o,
  output logic          s_cyc_o,
  output logic          s_stb_o,
  output logic          s_we_o,
  output logic [AW-1:0] s_adr_o,
  output logic [DW-1:0] s_dat_o,
  input  logic          s_stall_i,
  input  logic          s_ack_i,
  input  logic [DW-1:0] s_dat_i,
  output logic [1:0]    grant_o
);
  localparam logic [1:0] IDLE = 2'b00, GNT0 = 2'b01, GNT1 = 2'b10;
  logic [1:0] state, state_n;
  logic last_grant, lock0, lock1;
  logic [3:0] cnt, cnt_n, drain, drain_n, cnt_left, drain_left;
  logic [4:0] drain_sum;
  logic [7:0] wcnt, wcnt_n;
  logic g0, g1, gnt, req0, req1, full, inc, ack_own, to, chg;
  assign g0 = state == GNT0;
  assign g1 = state == GNT1;
  assign gnt = g0 | g1;
  assign grant_o = {g1, g0};
  assign req0 = m0_cyc_i & ~lock0;
  assign req1 = m1_cyc_i & ~lock1;
  assign full = cnt == 4'd15;
  assign s_cyc_o = g0 ? m0_cyc_i : g1 ? m1_cyc_i : 1'b0;
  assign s_stb_o = (g0 ? m0_stb_i : g1 ? m1_stb_i : 1'b0) & ~full;
  assign s_we_o = g0 ? m0_we_i : g1 ? m1_we_i : 1'b0;
  assign s_adr_o = g0 ? m0_adr_i : g1 ? m1_adr_i : '0;
  assign s_dat_o = g0 ? m0_dat_i : g1 ? m1_dat_i : '0;
  assign inc = s_stb_o & ~s_stall_i;
  // acks still owed to a previous owner are swallowed, never forwarded
  assign ack_own = gnt & s_ack_i & (drain == 4'd0);
  assign to = gnt & (cnt != 4'd0) & ~s_ack_i & (wcnt == 8'(TIMEOUT - 1));
  assign m0_stall_o = g0 ? (s_stall_i | full) : 1'b1;
  assign m1_stall_o = g1 ? (s_stall_i | full) : 1'b1;
  assign m0_ack_o = g0 & ack_own;
  assign m1_ack_o = g1 & ack_own;
  assign m0_err_o = g0 & to;
  assign m1_err_o = g1 & to;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign chg = state_n != state;
  assign cnt_left = cnt - {3'd0, ack_own & (cnt != 4'd0)};
  assign drain_left = drain - {3'd0, s_ack_i & (drain != 4'd0)};
  assign drain_sum = {1'b0, drain_left} + {1'b0, cnt_left};
  always_comb begin
    state_n = (g0 & ~to & m0_cyc_i) ? GNT0 :
              (g1 & ~to & m1_cyc_i) ? GNT1 :
              g0 ? (req1 ? GNT1 : IDLE) :
              g1 ? (req0 ? GNT0 : IDLE) :
              (req0 & req1) ? (last_grant ? GNT0 : GNT1) :
              req0 ? GNT0 : req1 ? GNT1 : IDLE;
    cnt_n = chg ? 4'd0 : (inc & ~ack_own) ? cnt + 4'd1 : (ack_own & ~inc) ? cnt_left : cnt;
    drain_n = to ? 4'd0 : (chg & gnt) ? (drain_sum[4] ? 4'hf : drain_sum[3:0]) : drain_left;
    wcnt_n = (chg | s_ack_i | (cnt == 4'd0) | ~gnt) ? 8'd0 : wcnt + 8'd1;
  end
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      state <= IDLE;
      last_grant <= 1'b1;
      cnt <= 4'd0;
      drain <= 4'd0;
      wcnt <= 8'd0;
      lock0 <= 1'b0;
      lock1 <= 1'b0;
    end else begin
      state <= state_n;
      last_grant <= (state_n == GNT0) ? 1'b0 : (state_n == GNT1) ? 1'b1 : last_grant;
      cnt <= cnt_n;
      drain <= drain_n;
      wcnt <= wcnt_n;
      lock0 <= m0_cyc_i & (lock0 | (g0 & to));
      lock1 <= m1_cyc_i & (lock1 | (g1 & to));
    end
endmodule

// File: tb/tb_wb_arb2_led.sv
// tb_wb_arb2_led: table-driven arbitration vectors plus scoreboarded ack/timeout/reset sequences
module tb_wb_arb2_led;
  localparam int AW = 4, DW = 8, TO = 20;
  logic clk = 0, rstn = 0;
  logic m0_cyc = 0, m0_stb = 0, m0_we = 0, m1_cyc = 0, m1_stb = 0, m1_we = 0;
  logic [AW-1:0] m0_adr = '0, m1_adr = '0, s_adr;
  logic [DW-1:0] m0_dat = '0, m1_dat = '0, m0_rdat, m1_rdat, s_wdat, s_rdat = '0;
  logic m0_stall, m0_ack, m0_err, m1_stall, m1_ack, m1_err;
  logic s_cyc, s_stb, s_we, s_stall = 0, s_ack = 0;
  logic [1:0] grant;
  int passed = 0, total = 0;
  int sbq[$];
  typedef struct {logic c0; logic c1; logic [1:0] g;} vec_t;
  vec_t vt[12];

  wb_arb2_led #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr), .m0_dat_i(m0_dat),
    .m0_stall_o(m0_stall), .m0_ack_o(m0_ack), .m0_err_o(m0_err), .m0_dat_o(m0_rdat),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr), .m1_dat_i(m1_dat),
    .m1_stall_o(m1_stall), .m1_ack_o(m1_ack), .m1_err_o(m1_err), .m1_dat_o(m1_rdat),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr), .s_dat_o(s_wdat),
    .s_stall_i(s_stall), .s_ack_i(s_ack), .s_dat_i(s_rdat), .grant_o(grant)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic ack_chk(input string nm);
    int e;
    if (sbq.size() == 0) begin
      total++;
      $display("FAIL %s: ack check with empty scoreboard at %0t", nm, $time);
      return;
    end
    e = sbq.pop_front();
    chk({nm, "_m0"}, 32'(m0_ack), 32'(e == 0));
    chk({nm, "_m1"}, 32'(m1_ack), 32'(e == 1));
    chk({nm, "_err"}, 32'(m0_err | m1_err), 32'd0);
  endtask

  initial begin
    vt[0] = '{1'b1, 1'b1, 2'b01};
    vt[1] = '{1'b1, 1'b1, 2'b01};
    vt[2] = '{1'b0, 1'b1, 2'b10};
    vt[3] = '{1'b1, 1'b1, 2'b10};
    vt[4] = '{1'b1, 1'b0, 2'b01};
    vt[5] = '{1'b0, 1'b0, 2'b00};
    vt[6] = '{1'b1, 1'b1, 2'b10};
    vt[7] = '{1'b0, 1'b0, 2'b00};
    vt[8] = '{1'b1, 1'b1, 2'b01};
    vt[9] = '{1'b0, 1'b0, 2'b00};
    vt[10] = '{1'b0, 1'b1, 2'b10};
    vt[11] = '{1'b0, 1'b0, 2'b00};
    #3;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_cyc", 32'(s_cyc), 32'd0);
    chk("rst_stall0", 32'(m0_stall), 32'd1);
    chk("rst_stall1", 32'(m1_stall), 32'd1);
    tick;
    tick;
    rstn = 1;
    // arbitration table: cyc only, so nothing is ever outstanding
    for (int i = 0; i < 12; i++) begin
      m0_cyc = vt[i].c0;
      m1_cyc = vt[i].c1;
      m0_adr = AW'($urandom);
      m1_adr = AW'($urandom);
      s_rdat = DW'($urandom);
      tick;
      #1;
      chk("arb_grant", 32'(grant), 32'(vt[i].g));
      chk("arb_stall0", 32'(m0_stall), 32'(vt[i].g != 2'b01));
      chk("arb_stall1", 32'(m1_stall), 32'(vt[i].g != 2'b10));
      chk("arb_cyc", 32'(s_cyc), 32'(vt[i].g == 2'b01 ? m0_cyc : vt[i].g == 2'b10 ? m1_cyc : 1'b0));
      chk("arb_adr", 32'(s_adr), 32'(vt[i].g == 2'b01 ? m0_adr : vt[i].g == 2'b10 ? m1_adr : '0));
      chk("arb_rdat0", 32'(m0_rdat), 32'(s_rdat));
      chk("arb_rdat1", 32'(m1_rdat), 32'(s_rdat));
    end
    // round robin, each owner releasing after one ack
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    for (int r = 0; r < 4; r++) begin
      tick;
      m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
      #1;
      chk("rr_grant", 32'(grant), (r % 2 == 0) ? 32'd1 : 32'd2);
      chk("rr_stb", 32'(s_stb), 32'd1);
      sbq.push_back(r % 2);
      tick;
      if (r % 2 == 0) m0_stb = 0; else m1_stb = 0;
      s_ack = 1;
      #1;
      ack_chk("rr_ack");
      tick;
      s_ack = 0;
      if (r % 2 == 0) m0_cyc = 0; else m1_cyc = 0;
      #1;
      chk("rr_hold", 32'(grant), (r % 2 == 0) ? 32'd1 : 32'd2);
    end
    tick;
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
    #1;
    chk("rr_last", 32'(grant), 32'd1);
    tick;
    #1;
    chk("rr_idle", 32'(grant), 32'd0);
    // LED-sweep slave: ack after each accept, then stalls 15 cycles
    m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_dat = 8'hA5; m0_adr = 4'd3;
    tick;
    #1;
    chk("led_grant", 32'(grant), 32'd1);
    chk("led_we", 32'(s_we), 32'd1);
    chk("led_wdat", 32'(s_wdat), 32'hA5);
    chk("led_adr", 32'(s_adr), 32'd3);
    chk("led_stall0", 32'(m0_stall), 32'd0);
    sbq.push_back(0);
    tick;
    s_ack = 1; s_stall = 1; m0_dat = 8'h5A;
    #1;
    ack_chk("led_ack1");
    chk("led_stallA", 32'(m0_stall), 32'd1);
    for (int i = 0; i < 14; i++) begin
      tick;
      s_ack = 0;
      #1;
      chk("led_stallB", 32'(m0_stall), 32'd1);
      chk("led_noack", 32'(m0_ack | m1_ack), 32'd0);
    end
    tick;
    s_stall = 0;
    #1;
    chk("led_free", 32'(m0_stall), 32'd0);
    chk("led_wdat2", 32'(s_wdat), 32'h5A);
    sbq.push_back(0);
    tick;
    s_ack = 1; s_stall = 1; m0_stb = 0;
    #1;
    ack_chk("led_ack2");
    tick;
    s_ack = 0; s_stall = 0; m0_cyc = 0; m0_we = 0;
    tick;
    #1;
    chk("led_idle", 32'(grant), 32'd0);
    // burst of 16 with acks withheld: 15 fit, 16th waits for first ack
    m0_cyc = 1; m0_stb = 1;
    tick;
    #1;
    chk("bur_grant", 32'(grant), 32'd1);
    for (int i = 0; i < 15; i++) begin
      chk("bur_acc", 32'(m0_stall), 32'd0);
      sbq.push_back(0);
      tick;
      #1;
    end
    chk("bur_full", 32'(m0_stall), 32'd1);
    chk("bur_nostb", 32'(s_stb), 32'd0);
    tick;
    #1;
    chk("bur_full2", 32'(m0_stall), 32'd1);
    s_ack = 1;
    #1;
    ack_chk("bur_ack");
    chk("bur_nostb2", 32'(s_stb), 32'd0);
    tick;
    s_ack = 0;
    #1;
    chk("bur_16th", 32'(m0_stall), 32'd0);
    chk("bur_stb16", 32'(s_stb), 32'd1);
    sbq.push_back(0);
    // owner leaves with strobes outstanding; their acks must go nowhere
    tick;
    m0_cyc = 0; m0_stb = 0; m1_cyc = 1;
    tick;
    #1;
    chk("late_grant", 32'(grant), 32'd2);
    for (int i = 0; i < 3; i++) begin
      s_ack = 1;
      #1;
      chk("late_ack0", 32'(m0_ack), 32'd0);
      chk("late_ack1", 32'(m1_ack), 32'd0);
      tick;
    end
    sbq.delete();
    s_ack = 0; m1_cyc = 0;
    tick;
    #1;
    chk("late_idle", 32'(grant), 32'd0);
    // timeout: single strobe never acked
    m0_cyc = 1; m0_stb = 1;
    tick;
    #1;
    chk("to_grant", 32'(grant), 32'd1);
    tick;
    m0_stb = 0;
    #1;
    for (int k = 1; k <= TO; k++) begin
      chk("to_err", 32'(m0_err), 32'(k == TO));
      chk("to_ack", 32'(m0_ack), 32'd0);
      tick;
      #1;
    end
    chk("to_idle", 32'(grant), 32'd0);
    chk("to_errdone", 32'(m0_err), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick;
      #1;
      chk("to_locked", 32'(grant), 32'd0);
    end
    m0_cyc = 0;
    tick;
    m0_cyc = 1;
    tick;
    #1;
    chk("to_regrant", 32'(grant), 32'd1);
    m0_cyc = 0;
    tick;
    tick;
    #1;
    chk("to_rel", 32'(grant), 32'd0);
    // reset while m1 owns with 3 strobes outstanding
    m1_cyc = 1; m1_stb = 1;
    tick;
    #1;
    chk("rs_grant", 32'(grant), 32'd2);
    tick;
    tick;
    tick;
    m1_stb = 0;
    #1;
    rstn = 0;
    #1;
    chk("rs_grant0", 32'(grant), 32'd0);
    chk("rs_cyc0", 32'(s_cyc), 32'd0);
    chk("rs_stall1", 32'(m1_stall), 32'd1);
    m1_cyc = 0;
    tick;
    rstn = 1;
    for (int i = 0; i < 2; i++) begin
      tick;
      s_ack = 1;
      #1;
      chk("rs_ack0", 32'(m0_ack), 32'd0);
      chk("rs_ack1", 32'(m1_ack), 32'd0);
    end
    s_ack = 0;
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/wb_arb2_led.md
WB_ARB2_LED -- requirements
Module: wb_arb2_led

Interface
REQ-001 SHALL have parameter AW, default 1, address width passed to the slave.
REQ-002 SHALL have parameter DW, default 32, data width.
REQ-003 SHALL have parameter TIMEOUT, default 64, cycles without ack before abort (legal 2..255).
REQ-004 SHALL have ports (one clock; reset is asynchronous and active-low):
- clk_i  in  1  sole clock, rising edge
- rstn_i  in  1  asynchronous active-low reset
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 Wishbone pipelined controls
- m0_adr_i  in  AW  master 0 address
- m0_dat_i  in  DW  master 0 write data
- m0_stall_o, m0_ack_o, m0_err_o  out  1 each  master 0 responses
- m0_dat_o  out  DW  master 0 read data
- m1_* ports  same as m0_*  master 1
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave controls
- s_adr_o  out  AW  slave address
- s_dat_o  out  DW  slave write data
- s_stall_i, s_ack_i  in  1 each  slave responses
- s_dat_i  in  DW  slave read data
- grant_o  out  2  one-hot owner, 2'b00 when idle

Function
REQ-005 SHALL implement registered FSM states IDLE, GNT0, GNT1; grant_o = {GNT1, GNT0}.
REQ-006 Request SHALL be mN_cyc_i high with lockN clear.
REQ-007 IDLE: one request -> that GNT; both -> master not in last_grant register; none -> stay. Grant takes effect next cycle.
REQ-008 GNTn: owner cyc high -> stay; owner cyc low -> GNT of other if requesting, else IDLE (direct handoff, no idle cycle).
REQ-009 last_grant SHALL update to n on every entry to GNTn.
REQ-010 Slave side SHALL be combinational mux of owner: s_cyc_o = owner cyc, s_stb_o = owner stb & ~full, s_we_o/s_adr_o/s_dat_o = owner values; IDLE drives all zero.
REQ-011 Owner stall_o = s_stall_i | full; non-owner stall_o = 1; owner ack_o = s_ack_i; non-owner ack_o = 0.
REQ-012 m0_dat_o and m1_dat_o SHALL both equal s_dat_i.
REQ-013 4-bit outstanding counter: +1 on s_stb_o & ~s_stall_i, -1 on s_ack_i, unchanged when both; full = (count == 15); never wraps; ack at 0 leaves 0.
REQ-014 Counter SHALL clear on every state change.
REQ-015 8-bit wait counter: increments each cycle in GNTn with count != 0 and no s_ack_i; clears on s_ack_i, count == 0, or state change.
REQ-016 wait counter reaching TIMEOUT-1 with no ack that cycle: owner err_o high for exactly that cycle, lockn set, FSM -> IDLE (or other master if requesting) next cycle.
REQ-017 lockN SHALL clear when mN_cyc_i is low; locked master SHALL not be granted.
REQ-018 Owner dropping cyc with count != 0 SHALL release normally; late s_ack_i in following cycles SHALL not reach either master.
REQ-019 err_o SHALL otherwise be 0; arbiter SHALL never assert ack_o and err_o together to a master.

Reset
REQ-020 rstn_i low SHALL asynchronously force IDLE, last_grant = 1 (master 0 wins first tie), both counters 0, lock0 = lock1 = 0, grant_o = 0; outputs then follow REQ-010/011.
REQ-021 Reset mid-transaction SHALL drop ownership immediately; no ack/err delivered after reset release for pre-reset strobes.

Verification
REQ-022 Tie after reset: m0, m1 cyc+stb high at cycle 0 -> grant_o = 01 at cycle 1, m1_stall_o = 1 throughout; m0 drops cyc -> grant_o = 10 next cycle.
REQ-023 Round robin: both request repeatedly, each releasing after one ack -> grant_o sequence 01,10,01,10.
REQ-024 LED-sweep slave, m0 write then second write -> s_stall_i high 15 cycles, m0_stall_o mirrors it, m0_ack_o one cycle after each accept, m1_ack_o = 0.
REQ-025 Slave model never acks, TIMEOUT = 8: m0 one strobe -> m0_err_o high exactly 8 cycles after accept, grant_o = 00 next; m0 keeps cyc -> no regrant until cyc low one cycle.
REQ-026 Pipelined burst of 16 strobes, slave acks withheld -> 15 accepted, 16th stalled (full), released by first ack.
REQ-027 rstn_i low while GNT1 with 3 outstanding -> grant_o = 00, s_cyc_o = 0 same cycle; later acks ignored.
